wb_grf: RTL and testbench

Consumer end of the M-to-W pipeline register. Takes the W-stage fields (`W_*`) and selects the write-back data. Commits that data to the 32x32 general register file and serves the two D-stage read ports, with write-to-read bypass. Also exposes the selected write data for hazard forwarding and keeps a retired-instruction counter.

---
 rtl/wb_grf.sv | 106 ++++++++++
 tb/tb_wb_grf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// W-stage write-back: data select, 32x32 GRF with bypass, retire counter.
// Optional simulation trace of register writes under GRF_TRACE_EN.
module wb_grf #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   W_Instr,
  input  logic [31:0]   W_PC,
  input  logic [DW-1:0] W_PC8,
  input  logic [DW-1:0] W_ALU_C,
  input  logic [DW-1:0] W_DM_OUT,
  input  logic [DW-1:0] W_MDU_OUT,
  input  logic [DW-1:0] W_EXT_OUT,
  input  logic [DW-1:0] W_CP0_OUT,
  input  logic          W_cmp,
  input  logic          W_chk,
  input  logic          W_RegWrite,
  input  logic          W_CondWr,
  input  logic [4:0]    W_A3,
  input  logic [2:0]    W_WDSel,
  input  logic [4:0]    D_A1,
  input  logic [4:0]    D_A2,
  output logic [DW-1:0] D_RD1,
  output logic [DW-1:0] D_RD2,
  output logic [DW-1:0] W_WD,
  output logic          W_WE,
  output logic [31:0]   retire_cnt
);

  logic [DW-1:0] rf_q [NREG];
  logic [31:0]   retire_q;
  logic [31:0]   retire_d;

  always_comb begin
    W_WD = '0;
    case (W_WDSel)
      3'd0:    W_WD = W_ALU_C;
      3'd1:    W_WD = W_DM_OUT;
      3'd2:    W_WD = W_PC8;
      3'd3:    W_WD = W_MDU_OUT;
      3'd4:    W_WD = W_EXT_OUT;
      3'd5:    W_WD = W_CP0_OUT;
      default: W_WD = '0;
    endcase
  end

  assign W_WE = W_RegWrite & ~W_chk
              & (~W_CondWr | W_cmp)
              & (W_A3 != 5'd0);

  // Same-cycle bypass so D sees the value being committed now.
  always_comb begin
    D_RD1 = '0;
    if (D_A1 == 5'd0)
      D_RD1 = '0;
    else if (W_WE && D_A1 == W_A3)
      D_RD1 = W_WD;
    else
      D_RD1 = rf_q[D_A1];
  end

  always_comb begin
    D_RD2 = '0;
    if (D_A2 == 5'd0)
      D_RD2 = '0;
    else if (W_WE && D_A2 == W_A3)
      D_RD2 = W_WD;
    else
      D_RD2 = rf_q[D_A2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (W_WE) begin
      rf_q[W_A3] <= W_WD;
    end
  end

  assign retire_d = (|W_Instr && !W_chk)
                  ? retire_q + 32'd1
                  : retire_q;

  always_ff @(posedge clk) begin
    if (reset)
      retire_q <= '0;
    else
      retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (!reset && W_WE)
      $display("@%h: $%d <= %h", W_PC, W_A3, W_WD);
  end
`else
  logic unused_pc;
  assign unused_pc = ^W_PC;
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: spec-level model checked every cycle
// plus directed vectors with literal expectations.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_Instr, W_PC, W_PC8, W_ALU_C, W_DM_OUT;
  logic [31:0] W_MDU_OUT, W_EXT_OUT, W_CP0_OUT;
  logic        W_cmp, W_chk, W_RegWrite, W_CondWr;
  logic [4:0]  W_A3, D_A1, D_A2;
  logic [2:0]  W_WDSel;
  logic [31:0] D_RD1, D_RD2, W_WD, retire_cnt;
  logic        W_WE;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_grf dut (
    .clk(clk), .reset(reset),
    .W_Instr(W_Instr), .W_PC(W_PC), .W_PC8(W_PC8),
    .W_ALU_C(W_ALU_C), .W_DM_OUT(W_DM_OUT),
    .W_MDU_OUT(W_MDU_OUT), .W_EXT_OUT(W_EXT_OUT),
    .W_CP0_OUT(W_CP0_OUT), .W_cmp(W_cmp), .W_chk(W_chk),
    .W_RegWrite(W_RegWrite), .W_CondWr(W_CondWr),
    .W_A3(W_A3), .W_WDSel(W_WDSel),
    .D_A1(D_A1), .D_A2(D_A2),
    .D_RD1(D_RD1), .D_RD2(D_RD2),
    .W_WD(W_WD), .W_WE(W_WE), .retire_cnt(retire_cnt)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: what the spec says the write data and enable must be.
  function automatic logic [31:0] m_wd();
    logic [31:0] srcs [8];
    srcs[0] = W_ALU_C;   srcs[1] = W_DM_OUT;
    srcs[2] = W_PC8;     srcs[3] = W_MDU_OUT;
    srcs[4] = W_EXT_OUT; srcs[5] = W_CP0_OUT;
    srcs[6] = 32'h0;     srcs[7] = 32'h0;
    return srcs[W_WDSel];
  endfunction

  function automatic logic m_we();
    if (!W_RegWrite || W_chk) return 1'b0;
    if (W_CondWr && !W_cmp) return 1'b0;
    return W_A3 != 0;
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == W_A3) return m_wd();
    return m_rf[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_rf[i]) m_rf[i] = 32'h0;
      m_cnt = 32'h0;
    end else begin
      if (m_we()) m_rf[W_A3] = m_wd();
      if (W_Instr != 0 && !W_chk) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("mdl_wd",  W_WD, m_wd());
      chk("mdl_we",  {31'h0, W_WE}, {31'h0, m_we()});
      chk("mdl_rd1", D_RD1, m_rd(D_A1));
      chk("mdl_rd2", D_RD2, m_rd(D_A2));
      chk("mdl_cnt", retire_cnt, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    W_Instr = 0; W_PC = 32'h3000; W_PC8 = 0;
    W_ALU_C = 0; W_DM_OUT = 0; W_MDU_OUT = 0;
    W_EXT_OUT = 0; W_CP0_OUT = 0;
    W_cmp = 0; W_chk = 0; W_RegWrite = 0; W_CondWr = 0;
    W_A3 = 0; W_WDSel = 0; D_A1 = 0; D_A2 = 0;
  endtask

  logic [31:0] c0;

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    en = 1'b1;
    cyc();
    reset = 1'b0;

    // All registers read zero after reset.
    for (int i = 0; i < 32; i++) begin
      D_A1 = 5'(i);
      D_A2 = 5'(31 - i);
      smp();
      chk("rst_rd1", D_RD1, 32'h0);
      chk("rst_rd2", D_RD2, 32'h0);
      cyc();
    end
    chk("rst_cnt", retire_cnt, 32'h0);

    // Bypass then committed value.
    W_Instr = 32'h1; W_RegWrite = 1; W_A3 = 5;
    W_WDSel = 0; W_ALU_C = 32'h1234ABCD; D_A1 = 5;
    smp();
    chk("byp_rd1", D_RD1, 32'h1234ABCD);
    chk("byp_we", {31'h0, W_WE}, 32'h1);
    cyc();
    idle(); D_A1 = 5;
    smp();
    chk("reg5", D_RD1, 32'h1234ABCD);
    chk("cnt1", retire_cnt, 32'h1);

    // Write to $0 is dropped.
    cyc();
    W_Instr = 32'h2; W_RegWrite = 1; W_A3 = 0;
    W_ALU_C = 32'hFFFFFFFF; D_A1 = 0;
    smp();
    chk("r0_we", {31'h0, W_WE}, 32'h0);
    chk("r0_rd", D_RD1, 32'h0);
    chk("r0_wd", W_WD, 32'hFFFFFFFF);

    // Conditional link not taken, then taken.
    cyc();
    idle();
    W_Instr = 32'h3; W_RegWrite = 1; W_CondWr = 1;
    W_cmp = 0; W_WDSel = 2; W_PC8 = 32'h3008; W_A3 = 31;
    D_A2 = 31;
    smp();
    chk("cw0_we", {31'h0, W_WE}, 32'h0);
    cyc();
    W_RegWrite = 0; W_Instr = 0;
    smp();
    chk("cw0_r31", D_RD2, 32'h0);
    cyc();
    W_Instr = 32'h3; W_RegWrite = 1; W_cmp = 1;
    smp();
    chk("cw1_byp", D_RD2, 32'h3008);
    cyc();
    W_RegWrite = 0; W_Instr = 0;
    smp();
    chk("cw1_r31", D_RD2, 32'h3008);

    // Cancelled instruction, then same one live.
    cyc();
    idle();
    c0 = retire_cnt;
    W_Instr = 32'h4; W_RegWrite = 1; W_A3 = 8;
    W_ALU_C = 32'hDEAD; W_chk = 1; D_A1 = 8;
    cyc();
    W_Instr = 0; W_RegWrite = 0; W_chk = 0;
    smp();
    chk("chk_r8", D_RD1, 32'h0);
    chk("chk_cnt", retire_cnt, c0);
    cyc();
    W_Instr = 32'h4; W_RegWrite = 1;
    cyc();
    W_Instr = 0; W_RegWrite = 0;
    smp();
    chk("live_r8", D_RD1, 32'hDEAD);
    chk("live_cnt", retire_cnt, c0 + 1);

    // Remaining mux codes; both ports bypass the same register.
    W_MDU_OUT = 32'hAAAA0003; W_DM_OUT = 32'hBBBB0001;
    W_EXT_OUT = 32'hCCCC0000; W_CP0_OUT = 32'h0000CC05;
    W_ALU_C = 32'h11111111; W_PC8 = 32'h22222222;
    for (int s = 0; s < 8; s++) begin
      cyc();
      W_Instr = 32'h5; W_RegWrite = 1; W_A3 = 12;
      W_WDSel = 3'(s); D_A1 = 12; D_A2 = 12;
      smp();
      chk("mux_eq", D_RD1, D_RD2);
    end
    chk("sel7", W_WD, 32'h0);
    cyc();
    idle(); D_A1 = 12;
    smp();
    chk("r12_sel7", D_RD1, 32'h0);
    cyc();
    W_Instr = 32'h6; W_RegWrite = 1; W_A3 = 12;
    W_WDSel = 5; W_CP0_OUT = 32'h0000CC05;
    cyc();
    idle(); D_A1 = 12;
    smp();
    chk("r12_cp0", D_RD1, 32'h0000CC05);

    // Write during reset is discarded.
    cyc();
    W_Instr = 32'h7; W_RegWrite = 1; W_A3 = 3; W_ALU_C = 9;
    cyc();
    W_ALU_C = 7; reset = 1;
    cyc();
    idle(); reset = 0; D_A1 = 3; D_A2 = 5;
    smp();
    chk("rst_r3", D_RD1, 32'h0);
    chk("rst_r5", D_RD2, 32'h0);
    chk("rst_cnt2", retire_cnt, 32'h0);

    // Counter wrap.
    cyc();
    force dut.retire_q = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_q;
    W_Instr = 32'h8;
    smp();
    chk("pre_wrap", retire_cnt, 32'hFFFFFFFF);
    cyc();
    W_Instr = 0;
    smp();
    chk("wrap", retire_cnt, 32'h0);

    cyc();
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
